screen_to_hex_q16: RTL and testbench

//  Inverse of the hex-to-screen transform: maps a Q16.16 screen position back to the

---
 rtl/screen_to_hex_q16.sv | 161 ++++++++++++++++
 tb/tb_screen_to_hex_q16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_to_hex_q16.sv
`default_nettype none
// ============================================================================
// Module   : screen_to_hex_q16
// Brief    : Q16.16 screen point -> axial pointy-top hex cell, 4-stage pipeline.
// Revision : 1.0
// ============================================================================
module screen_to_hex_q16 #(
  parameter int COORD_W = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic signed [31:0]        screen_x_q16,
  input  logic signed [31:0]        screen_y_q16,
  input  logic signed [31:0]        cam_x_q16,
  input  logic signed [31:0]        cam_y_q16,
  input  logic signed [31:0]        inv_zoom_q16,
  input  logic signed [31:0]        inv_size_q16,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic signed [COORD_W-1:0] q_hex,
  output logic signed [COORD_W-1:0] r_hex,
  output logic signed [31:0]        q_frac_q16,
  output logic signed [31:0]        r_frac_q16,
  output logic                      oob
);

  localparam logic signed [63:0] C_MAX = (64'sd1 <<< (COORD_W - 1)) - 64'sd1;
  localparam logic signed [63:0] C_MIN = -(64'sd1 <<< (COORD_W - 1));

  function automatic logic signed [63:0] sext64(input logic signed [31:0] a);
    return {{32{a[31]}}, a};
  endfunction

  function automatic logic signed [31:0] mulq(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] p;
    p = sext64(a) * sext64(b);
    return p[47:16];
  endfunction

  function automatic logic signed [31:0] frac_q(input logic signed [31:0] lx,
                                                input logic signed [31:0] ly);
    logic signed [63:0] p;
    p = 64'sd37837 * sext64(lx) - 64'sd21845 * sext64(ly);
    return p[47:16];
  endfunction

  function automatic logic signed [31:0] frac_r(input logic signed [31:0] ly);
    logic signed [63:0] p;
    p = 64'sd43691 * sext64(ly);
    return p[47:16];
  endfunction

  // Floor of (v + 0.5): rounds halves toward +inf.
  function automatic logic signed [17:0] rnd16(input logic signed [33:0] v);
    logic signed [33:0] t;
    t = v + 34'sd32768;
    return t[33:16];
  endfunction

  function automatic logic [32:0] absdiff(input logic signed [33:0] v,
                                          input logic signed [17:0] r);
    logic signed [34:0] d;
    d = {r[17], r, 16'h0000} - {v[33], v};
    if (d[34]) d = -d;
    return d[32:0];
  endfunction

  function automatic logic signed [63:0] sext20(input logic signed [19:0] a);
    return {{44{a[19]}}, a};
  endfunction

  logic en;
  assign en        = !valid_out || ready_in;
  assign ready_out = en;

  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, vo_q, vo_d;
  logic signed [31:0] wx_q, wx_d, wy_q, wy_d, isz_q, isz_d;
  logic signed [31:0] lx_q, lx_d, ly_q, ly_d;
  logic signed [31:0] qf_q, qf_d, rf_q, rf_d;
  logic signed [31:0] qfo_q, qfo_d, rfo_q, rfo_d;
  logic signed [COORD_W-1:0] qh_q, qh_d, rh_q, rh_d;
  logic               oob_q, oob_d;

  logic signed [33:0] vx, vy, vz;
  logic signed [17:0] rx, ry, rz;
  logic [32:0]        dx, dy, dz;
  logic signed [19:0] fq, fr;
  logic signed [63:0] fq64, fr64;

  always_comb begin
    v1_d  = valid_in;
    wx_d  = mulq(screen_x_q16, inv_zoom_q16) + cam_x_q16;
    wy_d  = mulq(screen_y_q16, inv_zoom_q16) + cam_y_q16;
    isz_d = inv_size_q16;

    v2_d  = v1_q;
    lx_d  = mulq(wx_q, isz_q);
    ly_d  = mulq(wy_q, isz_q);

    v3_d  = v2_q;
    qf_d  = frac_q(lx_q, ly_q);
    rf_d  = frac_r(ly_q);
  end

  always_comb begin
    vx = {{2{qf_q[31]}}, qf_q};
    vz = {{2{rf_q[31]}}, rf_q};
    vy = -vx - vz;
    rx = rnd16(vx);
    ry = rnd16(vy);
    rz = rnd16(vz);
    dx = absdiff(vx, rx);
    dy = absdiff(vy, ry);
    dz = absdiff(vz, rz);
    fq = {{2{rx[17]}}, rx};
    fr = {{2{rz[17]}}, rz};
    // Only q (x) and r (z) leave the block, so the y fix-up branch changes nothing.
    if (dx > dy && dx > dz)
      fq = -{{2{ry[17]}}, ry} - {{2{rz[17]}}, rz};
    else if (!(dy > dz))
      fr = -{{2{rx[17]}}, rx} - {{2{ry[17]}}, ry};
    fq64  = sext20(fq);
    fr64  = sext20(fr);
    vo_d  = v3_q;
    qfo_d = qf_q;
    rfo_d = rf_q;
    qh_d  = fq64[COORD_W-1:0];
    rh_d  = fr64[COORD_W-1:0];
    oob_d = (fq64 > C_MAX) || (fq64 < C_MIN) || (fr64 > C_MAX) || (fr64 < C_MIN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;  vo_q <= 1'b0;
      wx_q  <= '0;    wy_q <= '0;    isz_q <= '0;
      lx_q  <= '0;    ly_q <= '0;
      qf_q  <= '0;    rf_q <= '0;
      qfo_q <= '0;    rfo_q <= '0;
      qh_q  <= '0;    rh_q <= '0;    oob_q <= 1'b0;
    end else if (en) begin
      v1_q  <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;  vo_q <= vo_d;
      wx_q  <= wx_d;  wy_q <= wy_d;  isz_q <= isz_d;
      lx_q  <= lx_d;  ly_q <= ly_d;
      qf_q  <= qf_d;  rf_q <= rf_d;
      qfo_q <= qfo_d; rfo_q <= rfo_d;
      qh_q  <= qh_d;  rh_q <= rh_d;  oob_q <= oob_d;
    end
  end

  assign valid_out  = vo_q;
  assign q_hex      = qh_q;
  assign r_hex      = rh_q;
  assign q_frac_q16 = qfo_q;
  assign r_frac_q16 = rfo_q;
  assign oob        = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_screen_to_hex_q16.sv
`default_nettype none
// Bench for screen_to_hex_q16: directed and random points against a Q16.16 reference
// model; a second instance with COORD_W=8 covers out-of-range wrapping.
module tb_screen_to_hex_q16;

  logic        clk;
  logic        reset_n, valid_in, ready_in;
  logic [31:0] sx, sy, cx, cy, iz, isz;

  logic        ready_out, valid_out, oob;
  logic [15:0] q16, r16;
  logic [31:0] qf, rf;
  logic        ready_out8, valid_out8, oob8;
  logic [7:0]  q8, r8;
  logic [31:0] qf8, rf8;

  screen_to_hex_q16 #(.COORD_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .screen_x_q16(sx), .screen_y_q16(sy), .cam_x_q16(cx), .cam_y_q16(cy),
    .inv_zoom_q16(iz), .inv_size_q16(isz), .valid_out(valid_out), .ready_in(ready_in),
    .q_hex(q16), .r_hex(r16), .q_frac_q16(qf), .r_frac_q16(rf), .oob(oob));

  screen_to_hex_q16 #(.COORD_W(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out8),
    .screen_x_q16(sx), .screen_y_q16(sy), .cam_x_q16(cx), .cam_y_q16(cy),
    .inv_zoom_q16(iz), .inv_size_q16(isz), .valid_out(valid_out8), .ready_in(ready_in),
    .q_hex(q8), .r_hex(r8), .q_frac_q16(qf8), .r_frac_q16(rf8), .oob(oob8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q16, r16;
    logic [7:0]  q8, r8;
    logic [31:0] qf, rf;
    logic        o16, o8;
    int          acc;
    bit          lat;
    bit          dir;
    int          dq, dr;
    bit          do8;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   lat_chk = 0, dir_on = 0, dir_o8 = 0;
  int   dir_q = 0, dir_r = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint rnd(input longint v);
    return (v + 32768) >>> 16;
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input int x_s, input int y_s, input int c_x, input int c_y,
                                 input int zoom, input int size);
    exp_t   e;
    int     wx, wy, lx, ly, fq, fr;
    longint x, y, z, rx, ry, rz, dx, dy, dz;
    wx = int'((longint'(x_s) * longint'(zoom)) >>> 16) + c_x;
    wy = int'((longint'(y_s) * longint'(zoom)) >>> 16) + c_y;
    lx = int'((longint'(wx) * longint'(size)) >>> 16);
    ly = int'((longint'(wy) * longint'(size)) >>> 16);
    fq = int'((longint'(lx) * 37837 - longint'(ly) * 21845) >>> 16);
    fr = int'((longint'(ly) * 43691) >>> 16);
    x = fq; z = fr; y = -x - z;
    rx = rnd(x); ry = rnd(y); rz = rnd(z);
    dx = absl(rx * 65536 - x);
    dy = absl(ry * 65536 - y);
    dz = absl(rz * 65536 - z);
    if (dx > dy && dx > dz) rx = -ry - rz;
    else if (dy > dz)       ry = -rx - rz;
    else                    rz = -rx - ry;
    e = '{default: 0};
    e.q16 = rx[15:0]; e.r16 = rz[15:0];
    e.q8  = rx[7:0];  e.r8  = rz[7:0];
    e.qf  = fq;       e.rf  = fr;
    e.o16 = (rx > 32767) || (rx < -32768) || (rz > 32767) || (rz < -32768);
    e.o8  = (rx > 127) || (rx < -128) || (rz > 127) || (rz < -128);
    return e;
  endfunction

  // Scoreboard: everything is sampled on the falling edge, between drive and capture.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        expq.delete();
      end else begin
        if (valid_in && ready_out) begin
          e = model(sx, sy, cx, cy, iz, isz);
          e.acc = cyc; e.lat = lat_chk;
          e.dir = dir_on; e.dq = dir_q; e.dr = dir_r; e.do8 = dir_o8;
          expq.push_back(e);
        end
        if (valid_out && !ready_in) check("stall_ready", ready_out, 0);
        check("v8_match", valid_out8, valid_out);
        if (valid_out && ready_in) begin
          if (expq.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = expq.pop_front();
            check("q16", q16, e.q16);
            check("r16", r16, e.r16);
            check("qfrac", qf, e.qf);
            check("rfrac", rf, e.rf);
            check("oob16", oob, e.o16);
            check("q8", q8, e.q8);
            check("r8", r8, e.r8);
            check("oob8", oob8, e.o8);
            if (e.lat) check("latency", cyc - e.acc, 4);
            if (e.dir) begin
              check("dir_q16", q16, e.dq[15:0]);
              check("dir_r16", r16, e.dr[15:0]);
              check("dir_q8", q8, e.dq[7:0]);
              check("dir_oob8", oob8, e.do8);
            end
          end
        end
      end
    end
  end

  task automatic send(input int x_s, input int y_s, input int c_x, input int c_y,
                      input int zoom, input int size);
    bit ok;
    ok = 0;
    sx = x_s; sy = y_s; cx = c_x; cy = c_y; iz = zoom; isz = size;
    valid_in = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (ready_out) ok = 1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_dir(input int x_s, input int y_s, input int c_x, input int zoom,
                          input int q, input int r, input bit o8);
    dir_on = 1; dir_q = q; dir_r = r; dir_o8 = o8;
    send(x_s, y_s, c_x, 0, zoom, 65536);
    dir_on = 0;
  endtask

  task automatic send_rand();
    send(int'($urandom_range(0, 4000000)) - 2000000, int'($urandom_range(0, 4000000)) - 2000000,
         int'($urandom_range(0, 2000000)) - 1000000, int'($urandom_range(0, 2000000)) - 1000000,
         int'($urandom_range(8192, 262144)), int'($urandom_range(2048, 131072)));
  endtask

  bit rand_done;

  initial begin
    reset_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    sx = 0; sy = 0; cx = 0; cy = 0; iz = 0; isz = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_q", q16, 0);
    check("rst_r", r16, 0);
    check("rst_qf", qf, 0);
    check("rst_rf", rf, 0);
    check("rst_oob", oob, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", ready_out, 1);
    @(posedge clk); #1;

    // Identity mapping, origin cell and first-beat latency.
    lat_chk = 1;
    send_dir(0, 0, 0, 65536, 0, 0, 0);
    lat_chk = 0;
    repeat (6) @(posedge clk); #1;
    send_dir(113512, 0, 0, 65536, 1, 0, 0);
    send_dir(56756, 98304, 0, 65536, 0, 1, 0);
    send_dir(-113512, 0, 0, 65536, -1, 0, 0);
    send_dir(0, 0, 113512, 65536, 1, 0, 0);
    send_dir(227024, 0, 0, 32768, 1, 0, 0);
    send_dir(113512 * 200, 0, 0, 65536, 200, 0, 1);
    repeat (8) @(posedge clk); #1;

    // Backpressure window over an 8-beat stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk); #1;
        ready_in = 1'b0;
        repeat (7) @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join
    repeat (12) @(posedge clk); #1;
    check("t4_drained", expq.size(), 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send_rand();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_valid_out", valid_out, 0);
    repeat (8) @(posedge clk); #1;

    // Random traffic with random gaps and random downstream stalls.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_rand();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ready_in = ($urandom_range(0, 9) > 2);
        end
        ready_in = 1'b1;
      end
    join

    for (int k = 0; k < 100 && expq.size() != 0; k++) @(posedge clk);
    #1;
    check("final_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
